// File: rtl/jtcontra_gfx_pkg.sv
// Shared definitions for the Contra GFX tile path: FSM encoding, map-entry layout
// and ROM word addressing.
package jtcontra_gfx_pkg;

   localparam int TILES_PER_LINE = 33;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MAP  = 3'd1;
   localparam logic [2:0] ST_MAPD = 3'd2;
   localparam logic [2:0] ST_ROM0 = 3'd3;
   localparam logic [2:0] ST_ROM1 = 3'd4;
   localparam logic [2:0] ST_DRAW = 3'd5;

   localparam int MAP_CODE_LSB  = 0;
   localparam int MAP_CODE_W    = 12;
   localparam int MAP_PAL_LSB   = 12;
   localparam int MAP_HFLIP_BIT = 15;

   typedef struct packed {
      logic       hflip;
      logic [2:0] pal;
      logic [11:0] code;
   } map_entry_t;

   // ROM word address layout: {code, fine_y, half}
   function automatic logic [15:0] rom_word_addr(input logic [11:0] code,
                                                 input logic [2:0] fy,
                                                 input logic half);
      return {code, fy, half};
   endfunction

endpackage

// File: rtl/jtcontra_tile_fetch_if.sv
// Bundle of map, ROM-slot and line-buffer signals around the tile fetcher.
// ROM handshake: rom_cs requests rom_addr; rom_ok is honoured only from the second cycle
// a given address has been presented, and the word is taken on the first such cycle with rom_ok high.
interface jtcontra_tile_fetch_if;
   import jtcontra_gfx_pkg::*;

   logic        line_start;
   logic [7:0]  vrender;
   logic [8:0]  hscroll;
   logic [7:0]  vscroll;
   logic [10:0] vram_addr;
   logic [15:0] vram_data;
   logic        rom_cs;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic        rom_ok;
   logic        buf_we;
   logic [7:0]  buf_addr;
   logic [6:0]  buf_data;
   logic        busy;
   logic        done;
   logic [2:0]  state;

   modport master (
      input  line_start, vrender, hscroll, vscroll, vram_data, rom_data, rom_ok,
      output vram_addr, rom_cs, rom_addr, buf_we, buf_addr, buf_data, busy, done, state
   );

   modport slave (
      output line_start, vrender, hscroll, vscroll, vram_data, rom_data, rom_ok,
      input  vram_addr, rom_cs, rom_addr, buf_we, buf_addr, buf_data, busy, done, state
   );

endinterface

// File: rtl/jtcontra_tile_unpack.sv
// Picks one 4bpp pixel out of the two ROM words of a tile row, honouring hflip.
module jtcontra_tile_unpack
   import jtcontra_gfx_pkg::*;
(
   input  logic [15:0] w0,
   input  logic [15:0] w1,
   input  logic [2:0]  idx,
   input  logic        hflip,
   output logic [3:0]  pix
);
   logic [2:0]  k;
   logic [4:0]  lsb;
   logic [31:0] w;

   assign k   = hflip ? ~idx : idx;
   assign w   = {w0, w1};
   // pixel 0 sits in the top nibble of w0
   assign lsb = 5'd28 - {k, 2'b00};
   assign pix = w[lsb +: 4];

endmodule

// File: rtl/jtcontra_tile_fetch.sv
// Per-line tilemap fetcher: walks 33 scrolled tiles, reads two ROM words per tile
// and writes the unpacked pixels into the 256-pixel line buffer.
module jtcontra_tile_fetch
   import jtcontra_gfx_pkg::*;
(
   input  logic clk,
   input  logic rst,
   jtcontra_tile_fetch_if.master bus
);
   logic [2:0]  state;
   logic [5:0]  n;
   logic [2:0]  i;
   logic [4:0]  trow;
   logic [2:0]  fy;
   logic [5:0]  col0;
   logic [2:0]  fx;
   logic [2:0]  pal;
   logic        hflip;
   logic [15:0] w0, w1;
   logic        armed;
   logic [15:0] rom_addr;
   logic        buf_we;
   logic [7:0]  buf_addr;
   logic [6:0]  buf_data;
   logic        busy, done;
   logic [7:0]  y;
   logic [8:0]  x;
   logic [3:0]  pix;
   logic        last_tile;
   map_entry_t  entry;

   assign y         = bus.vrender + bus.vscroll;
   assign x         = {n, i} - {6'd0, fx};
   assign entry     = map_entry_t'(bus.vram_data);
   assign last_tile = (n == 6'(TILES_PER_LINE - 1));

   assign bus.vram_addr = {trow, col0 + n};
   assign bus.rom_cs    = (state == ST_ROM0) || (state == ST_ROM1);
   assign bus.rom_addr  = rom_addr;
   assign bus.buf_we    = buf_we;
   assign bus.buf_addr  = buf_addr;
   assign bus.buf_data  = buf_data;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.state     = state;

   jtcontra_tile_unpack u_unpack (
      .w0    (w0),
      .w1    (w1),
      .idx   (i),
      .hflip (hflip),
      .pix   (pix)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         n        <= '0;
         i        <= '0;
         trow     <= '0;
         fy       <= '0;
         col0     <= '0;
         fx       <= '0;
         pal      <= '0;
         hflip    <= 1'b0;
         w0       <= '0;
         w1       <= '0;
         armed    <= 1'b0;
         rom_addr <= '0;
         buf_we   <= 1'b0;
         buf_addr <= '0;
         buf_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done   <= 1'b0;
         buf_we <= 1'b0;
         // a new line start always wins, even in the middle of a fetch
         if (bus.line_start) begin
            trow  <= y[7:3];
            fy    <= y[2:0];
            col0  <= bus.hscroll[8:3];
            fx    <= bus.hscroll[2:0];
            n     <= '0;
            i     <= '0;
            busy  <= 1'b1;
            state <= ST_MAP;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_MAP:  state <= ST_MAPD;
               ST_MAPD: begin
                  pal      <= entry.pal;
                  hflip    <= entry.hflip;
                  rom_addr <= rom_word_addr(entry.code, fy, 1'b0);
                  armed    <= 1'b0;
                  state    <= ST_ROM0;
               end
               // the first cycle on a new address carries a stale rom_ok
               ST_ROM0: begin
                  if (!armed) armed <= 1'b1;
                  else if (bus.rom_ok) begin
                     w0          <= bus.rom_data;
                     rom_addr[0] <= 1'b1;
                     armed       <= 1'b0;
                     state       <= ST_ROM1;
                  end
               end
               ST_ROM1: begin
                  if (!armed) armed <= 1'b1;
                  else if (bus.rom_ok) begin
                     w1          <= bus.rom_data;
                     rom_addr[0] <= 1'b0;
                     armed       <= 1'b0;
                     i           <= '0;
                     state       <= ST_DRAW;
                  end
               end
               ST_DRAW: begin
                  buf_we   <= ~x[8];
                  buf_addr <= x[7:0];
                  buf_data <= {pal, pix};
                  i        <= i + 3'd1;
                  if (i == 3'd7) begin
                     if (last_tile) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                     end else begin
                        n     <= n + 6'd1;
                        state <= ST_MAP;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtcontra_tile_fetch.sv
// Directed bench for jtcontra_tile_fetch: map/ROM models, write scoreboard, latency
// and handshake checks, abort and reset mid-fetch.
module tb_jtcontra_tile_fetch;
   import jtcontra_gfx_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtcontra_tile_fetch_if bus();

   jtcontra_tile_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] map_mem [2048];
   logic [15:0] rom_mem [65536];
   logic        rom_bad = 1'b0;

   always @(posedge clk) bus.vram_data <= map_mem[bus.vram_addr];
   assign bus.rom_data = rom_bad ? 16'hdead : rom_mem[bus.rom_addr];

   int tests = 0;
   int fails = 0;

   logic [14:0] exp_q[$];
   logic [14:0] act_q[$];
   logic [10:0] map_q[$];

   int          cyc = 0;
   int          busy_cyc = 0;
   int          done_cyc = 0;
   int          done_cnt = 0;
   int          rom1_cnt = 0;
   int          hs_viol = 0;
   logic [2:0]  rom_fy = '0;
   logic        rom_fy_seen = 1'b0;
   logic        busy_q = 1'b0;
   logic        cs_q = 1'b0;
   logic [2:0]  state_q = '0;
   logic [15:0] addr_q = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // monitor: everything sampled on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (bus.buf_we) act_q.push_back({bus.buf_addr, bus.buf_data});
         if (bus.done) begin done_cnt++; done_cyc = cyc; end
         if (bus.busy && !busy_q) busy_cyc = cyc;
         if (bus.state == ST_MAP && state_q != ST_MAP) map_q.push_back(bus.vram_addr);
         if (bus.state == ST_ROM1) rom1_cnt++;
         if (bus.state == ST_ROM0 && !rom_fy_seen) begin
            rom_fy = bus.rom_addr[3:1];
            rom_fy_seen = 1'b1;
         end
         if (bus.rom_cs !== (bus.state == ST_ROM0 || bus.state == ST_ROM1)) hs_viol++;
         if (bus.rom_cs && cs_q && bus.state == state_q && bus.rom_addr != addr_q) hs_viol++;
      end
      busy_q  = bus.busy;
      cs_q    = bus.rom_cs;
      state_q = bus.state;
      addr_q  = bus.rom_addr;
   end

   task automatic clear_mon();
      act_q.delete();
      map_q.delete();
      rom1_cnt    = 0;
      rom_fy_seen = 1'b0;
   endtask

   task automatic start_line(input int vr, input int hs, input int vs);
      @(posedge clk); #1;
      bus.vrender    = 8'(vr);
      bus.hscroll    = 9'(hs);
      bus.vscroll    = 8'(vs);
      bus.line_start = 1'b1;
      @(posedge clk); #1;
      bus.line_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int start_cnt = done_cnt;
      int k = 0;
      while (done_cnt == start_cnt && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done"}, done_cnt - start_cnt, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] s, input string tag);
      int k = 0;
      while (bus.state !== s && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_reach"}, bus.state, s);
   endtask

   // reference model of one line of writes
   task automatic build_exp(input int vr, input int hs, input int vs);
      logic [7:0]  y;
      logic [15:0] e;
      logic [31:0] w;
      int col, code, k, pix, x, fx, col0;
      exp_q.delete();
      y    = 8'(vr + vs);
      col0 = (hs >> 3) & 63;
      fx   = hs & 7;
      for (int n = 0; n < 33; n++) begin
         col  = (col0 + n) % 64;
         e    = map_mem[int'(y[7:3]) * 64 + col];
         code = int'(e[11:0]);
         w    = {rom_mem[code * 16 + int'(y[2:0]) * 2], rom_mem[code * 16 + int'(y[2:0]) * 2 + 1]};
         for (int i = 0; i < 8; i++) begin
            k   = e[15] ? 7 - i : i;
            pix = int'((w >> (28 - 4 * k)) & 32'hf);
            x   = n * 8 + i - fx;
            if (x >= 0 && x < 256) exp_q.push_back({8'(x), e[14:12], 4'(pix)});
         end
      end
   endtask

   task automatic compare_line(input string tag, input int vr, input int hs, input int vs);
      int mism = 0;
      int lim;
      build_exp(vr, hs, vs);
      check({tag, "_nwr"}, act_q.size(), exp_q.size());
      lim = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int k = 0; k < lim; k++) if (act_q[k] !== exp_q[k]) mism++;
      check({tag, "_wr"}, mism, 0);
   endtask

   initial begin
      int dc;
      for (int a = 0; a < 65536; a++) rom_mem[a] = 16'(a * 40503 + 7);
      for (int a = 0; a < 2048; a++) map_mem[a] = 16'(a * 2654 + 3);
      map_mem[0] = 16'h8005;
      map_mem[1] = 16'h1005;
      rom_mem[16'h0050] = 16'h0123;
      rom_mem[16'h0051] = 16'h4567;

      bus.line_start = 1'b0;
      bus.vrender    = '0;
      bus.hscroll    = '0;
      bus.vscroll    = '0;
      bus.rom_ok     = 1'b1;

      // reset values
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_rom_cs",   bus.rom_cs,    1'b0);
      check("rst_rom_addr", bus.rom_addr,  16'h0);
      check("rst_vram",     bus.vram_addr, 11'h0);
      check("rst_buf_we",   bus.buf_we,    1'b0);
      check("rst_buf_addr", bus.buf_addr,  8'h0);
      check("rst_buf_data", bus.buf_data,  7'h0);
      check("rst_busy",     bus.busy,      1'b0);
      check("rst_done",     bus.done,      1'b0);
      check("rst_state",    bus.state,     ST_IDLE);
      @(posedge clk); #1 rst = 1'b0;

      // A: no scroll, hflip tile at column 0
      clear_mon();
      start_line(0, 0, 0);
      wait_done("a");
      check("a_latency", done_cyc - busy_cyc, 462);
      check("a_busy_low", bus.busy, 1'b0);
      check("a_nmap", map_q.size(), 33);
      check("a_last_addr", act_q[255][14:7], 8'd255);
      for (int k = 0; k < 8; k++) check("a_hflip_px", act_q[k], {8'(k), 3'd0, 4'(7 - k)});
      check("a_rom1_cycles", rom1_cnt, 66);
      compare_line("a", 0, 0, 0);

      // B: hscroll 0x00B, fine x = 3, starts at column 1
      clear_mon();
      start_line(0, 11, 0);
      wait_done("b");
      check("b_first_col", map_q[0], 11'd1);
      check("b_first_px", act_q[0], {8'd0, 7'h13});
      check("b_px4", act_q[4], {8'd4, 7'h17});
      check("b_tail", act_q[253][14:7], 8'd253);
      compare_line("b", 0, 11, 0);

      // C: vertical wrap and column wrap 63 -> 0
      clear_mon();
      start_line(250, 9'h1f8, 10);
      wait_done("c");
      check("c_col0", map_q[0], 11'd63);
      check("c_col1", map_q[1], 11'd0);
      check("c_col2", map_q[2], 11'd1);
      check("c_fy", rom_fy, 3'd4);
      compare_line("c", 250, 9'h1f8, 10);

      // D: stale rom_ok, then a 5-cycle stall on the first ROM1 word
      clear_mon();
      start_line(3, 5, 0);
      wait_state(ST_ROM1, "d");
      rom_bad = 1'b1;
      @(posedge clk); #1 bus.rom_ok = 1'b0;
      repeat (5) @(posedge clk);
      #1 bus.rom_ok = 1'b1;
      rom_bad = 1'b0;
      wait_done("d");
      check("d_rom1_cycles", rom1_cnt, 71);
      check("d_latency", done_cyc - busy_cyc, 467);
      compare_line("d", 3, 5, 0);

      // E: abort at tile 10 with a new line_start
      clear_mon();
      dc = done_cnt;
      start_line(40, 100, 16);
      while (map_q.size() < 11 && cyc < 100000) @(negedge clk);
      check("e_tile10", map_q.size(), 11);
      wait_state(ST_DRAW, "e");
      @(negedge clk);
      @(posedge clk); #1;
      bus.vrender    = 8'd77;
      bus.hscroll    = 9'd300;
      bus.vscroll    = 8'd5;
      bus.line_start = 1'b1;
      @(posedge clk); #1;
      bus.line_start = 1'b0;
      clear_mon();
      repeat (6) @(negedge clk);
      check("e_no_wr_after_abort", act_q.size(), 0);
      check("e_restart_col", map_q[0], {5'(8'(77 + 5) >> 3), 6'(300 >> 3)});
      wait_done("e");
      check("e_done_once", done_cnt - dc, 1);
      compare_line("e", 77, 300, 5);

      // F: reset mid-fetch
      start_line(0, 0, 0);
      wait_state(ST_DRAW, "f");
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      clear_mon();
      dc = done_cnt;
      repeat (20) @(negedge clk);
      check("f_no_wr", act_q.size(), 0);
      check("f_busy", bus.busy, 1'b0);
      check("f_state", bus.state, ST_IDLE);
      check("f_no_done", done_cnt - dc, 0);

      check("handshake", hs_viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jtcontra_tile_fetch.md
# jtcontra_tile_fetch

Per-line tilemap fetcher for one Contra GFX layer. On each line-start pulse it walks the scrolled tile map and reads two 16-bit ROM words per tile through the ROM slot handshake. It unpacks the 4bpp pixels and writes them into a 256-pixel line buffer. It sits between the GFX1/GFX2 ROM slots of the SDRAM arbiter (it drives their address and chip-select) and the line-buffer/colour-mixer stage of the video path.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk  in  1  system clock; all logic updates every cycle, no clock enable
- rst  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse at the start of HBLANK; begins the fetch for the next line
- vrender  in  8  line number to be fetched
- hscroll  in  9  horizontal scroll in pixels
- vscroll  in  8  vertical scroll in pixels
- vram_addr  out  11  tile map address {trow[4:0], tcol[5:0]}
- vram_data  in  16  map entry; fixed 1-cycle read latency; code = [11:0], pal = [14:12], hflip = [15]
- rom_cs  out  1  ROM request
- rom_addr  out  16  ROM word address {code[11:0], fine_y[2:0], half}
- rom_data  in  16  ROM word
- rom_ok  in  1  ROM data valid for the current rom_addr
- buf_we  out  1  line-buffer write strobe
- buf_addr  out  8  line-buffer pixel x
- buf_data  out  7  {pal[2:0], pix[3:0]}
- busy  out  1  high while a line fetch is in progress
- done  out  1  one-cycle pulse when tile 32 finishes drawing

## Operation
Setup on a line-start pulse:
- Latch y = vrender + vscroll (8-bit, wraps).
- Latch trow = y[7:3], fy = y[2:0], col0 = hscroll[8:3] and fx = hscroll[2:0].
- Set tile counter n = 0.

The fetch walks 33 tiles (n = 0..32), column tcol = (col0 + n) mod 64.

FSM states:
- IDLE → MAP on line_start.
- MAP: drive vram_addr; go to MAPD.
- MAPD: latch code, pal and hflip from vram_data; go to ROM0.
- ROM0: rom_cs = 1, half = 0. Ignore rom_ok in the first cycle after rom_addr changes (stale ok). Accept it from the second cycle on, latch w0, then go to ROM1.
- ROM1: same as ROM0 with half = 1; latch w1, then go to DRAW.
- DRAW: 8 cycles, i = 0..7.
  - Pixel p_i = {w0,w1}[31-4i -: 4]. With hflip the pixel order is reversed (p_7 first).
  - Target x = n*8 + i − fx, 9-bit. buf_we = 1 only when x < 256. buf_addr = x[7:0].
  - After i = 7: if n = 32, pulse done and go to IDLE; otherwise n++ and go to MAP.
- rom_cs is low in every state except ROM0 and ROM1.

Boundary cases:
- line_start in any non-IDLE state aborts the current line and restarts setup for the new line. No partial writes are issued after the abort cycle.
- Pixel value 0 is written like any other value (transparency is decided downstream).
- tcol wraps from 63 to 0. The map is 64×32 tiles.
- rst mid-fetch returns to IDLE immediately, with no further writes.

## Timing
- Reset values: rom_cs = 0, rom_addr = 0, vram_addr = 0, buf_we = 0, buf_addr = 0, buf_data = 0, busy = 0, done = 0, FSM in IDLE.
- busy goes high the cycle after line_start and drops in the cycle done pulses.
- Minimum tile time, with rom_ok already high: MAP 1 + MAPD 1 + ROM0 2 + ROM1 2 + DRAW 8 = 14 cycles. A full line therefore takes at least 462 cycles, which fits the 1536-cycle line budget at 24 MHz with margin for SDRAM latency.
- rom_addr is stable for the whole time rom_cs is high. It changes only on a ROM0→ROM1 or ROM1→DRAW transition.
- Writes are registered. buf_we, buf_addr and buf_data change together one cycle after the DRAW-state counter value.

## Structure
- Shared package jtcontra_gfx_pkg holds:
  - the FSM state encoding;
  - TILES_PER_LINE = 33;
  - map-entry field positions (code, pal, hflip);
  - the ROM address layout.
- One sub-module, jtcontra_tile_unpack: combinational selection of the 4-bit pixel from {w0,w1}, i and hflip.

## Test plan
- Reset with hscroll = 0, vscroll = 0 and rom_ok tied high → all outputs 0. After line_start, 256 writes to x = 0..255, done arrives exactly 462 cycles after busy rises, and the tile-32 writes are all suppressed.
- Map entry 0x8005 (code 5, pal 0, hflip), ROM words 0x0123 / 0x4567, fy = 0 → tile-0 pixels written in the order 7,6,5,4,3,2,1,0.
- hscroll = 0x00B (col0 = 1, fx = 3) → tile n = 0 pixels 0–2 suppressed, pixel 3 lands at x = 0. Tile 32 writes x = 253..255 only. First vram_addr column = 1.
- vrender = 250, vscroll = 10 → y = 4 (wraps), trow = 0, rom_addr[3:1] = 4. hscroll = 0x1F8 → column sequence 63, 0, 1, ….
- rom_ok held high across an address change, then low for 5 cycles, then high → data is not latched in the first cycle after the change, and the FSM waits the full 5 cycles.
- line_start asserted at tile 10 → no write is issued after the abort cycle, n restarts at 0, and exactly one done pulse follows for the new line.
